// File: rtl/chnlnk_frame_tx.sv
// chnlnk_frame_tx
// Downstream stage of the channel-link frame sequencer. Turns the sequencer's
// per-slot strobes into the 16-bit transmit word stream, with per-byte K-char
// flags, for the 8b/10b serializer. Header words come from HDR_DATA and samples
// from the FIFO (DIN). The sample tail carries the sample index, the running
// CRC-16-CCITT, a status word and a constant trailer. Empty slots carry idle
// commas, and LAST_WRD emits an EOF K-word.
//
// Build option:
//   CHNLNK_SEQ_CHK_EN - when defined, an expected-SEQ checker drives a sticky
//                       SEQ_ERR flag, which also appears in tail word 98.
//                       When undefined, SEQ_ERR is tied low.
//
// Ports:
//   CLK       in   1   clock
//   RST       in   1   asynchronous, active-high reset
//   VALID     in   1   word slot valid this cycle
//   HDR       in   1   slot is a header word (SEQ 0..3)
//   SEQ       in   7   word index within header or sample
//   CLR_CRC   in   1   preset CRC to CRC_INIT
//   LAST_WRD  in   1   event finished, emit EOF_WORD
//   HDR_DATA  in  64   four header words, word n = HDR_DATA[16n+15:16n]
//   DIN       in  16   FIFO sample data
//   SAMP_IDX  in   7   sample number placed in tail word 96
//   TXD       out 16   transmit word (one CLK after the strobes)
//   TXK       out  2   K flags, bit0 -> TXD[7:0], bit1 -> TXD[15:8]
//   CRC_OUT   out 16   running CRC register
//   SEQ_ERR   out  1   sticky sequence-error flag
module chnlnk_frame_tx #(
    parameter logic [15:0] IDLE_WORD = 16'h50BC,
    parameter logic [15:0] EOF_WORD  = 16'hF7F7,
    parameter logic [15:0] TRL_WORD  = 16'hE0E0,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID,
    input  logic        HDR,
    input  logic [6:0]  SEQ,
    input  logic        CLR_CRC,
    input  logic        LAST_WRD,
    input  logic [63:0] HDR_DATA,
    input  logic [15:0] DIN,
    input  logic [6:0]  SAMP_IDX,
    output logic [15:0] TXD,
    output logic [1:0]  TXK,
    output logic [15:0] CRC_OUT,
    output logic        SEQ_ERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_TAIL   = 2'd3;

    logic [15:0] txd_q, txd_d;
    logic [1:0]  txk_q, txk_d;
    logic [15:0] crc_q, crc_d;
    logic [1:0]  state_q, state_d;
    logic        seq_err;

    // CRC-16-CCITT, poly 0x1021, MSB first, 16 data bits in one cycle.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                               input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Word selection, in strobe priority order.
    always_comb begin
        txd_d = IDLE_WORD;
        txk_d = 2'b01;
        if (LAST_WRD) begin
            txd_d = EOF_WORD;
            txk_d = 2'b11;
        end else if (VALID) begin
            txk_d = 2'b00;
            if (HDR)                  txd_d = HDR_DATA[{SEQ[1:0], 4'b0000} +: 16];
            else if (SEQ <= 7'd95)    txd_d = DIN;
            else if (SEQ == 7'd96)    txd_d = {9'd0, SAMP_IDX};
            else if (SEQ == 7'd97)    txd_d = crc_q;
            else if (SEQ == 7'd98)    txd_d = {9'd0, seq_err, 6'd0};
            else if (SEQ == 7'd99)    txd_d = TRL_WORD;
            else begin
                txd_d = IDLE_WORD;
                txk_d = 2'b01;
            end
        end
    end

    // CRC covers sample words 0..95 plus the SAMP_IDX word at 96. Sample
    // slots only count once an event has started (state left IDLE).
    always_comb begin
        logic        upd;
        logic [15:0] cdata;
        upd   = VALID && !HDR && (SEQ <= 7'd96) && (state_q != ST_IDLE);
        cdata = (SEQ == 7'd96) ? {9'd0, SAMP_IDX} : DIN;
        crc_d = crc_q;
        if (CLR_CRC)  crc_d = CRC_INIT;
        else if (upd) crc_d = crc16_word(crc_q, cdata);
    end

    // Tracking FSM: where in the event the sequencer currently is.
    always_comb begin
        state_d = state_q;
        if (LAST_WRD) begin
            state_d = ST_IDLE;
        end else if (VALID) begin
            case (state_q)
                ST_IDLE:   if (HDR)                          state_d = ST_HEADER;
                ST_HEADER: if (!HDR && SEQ == 7'd0)          state_d = ST_SAMPLE;
                ST_SAMPLE: if (!HDR && SEQ == 7'd96)         state_d = ST_TAIL;
                ST_TAIL:   if (!HDR && SEQ == 7'd0)          state_d = ST_SAMPLE;
                default:                                     state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            txd_q   <= IDLE_WORD;
            txk_q   <= 2'b01;
            crc_q   <= CRC_INIT;
            state_q <= ST_IDLE;
        end else begin
            txd_q   <= txd_d;
            txk_q   <= txk_d;
            crc_q   <= crc_d;
            state_q <= state_d;
        end
    end

`ifdef CHNLNK_SEQ_CHK_EN
    logic [6:0] exp_q, exp_d;
    logic       err_q, err_d;

    // Expected SEQ advances on every valid slot and restarts at 0 after the
    // last header word, after the trailer and while idle. A new event
    // (header word 0) clears the sticky error.
    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (LAST_WRD) begin
            exp_d = 7'd0;
        end else if (VALID) begin
            if ((HDR && SEQ == 7'd3) || (!HDR && SEQ == 7'd99)) exp_d = 7'd0;
            else                                                 exp_d = exp_q + 7'd1;
            if (SEQ != exp_q || SEQ > 7'd99) err_d = 1'b1;
            if (HDR && SEQ == 7'd0) begin
                err_d = 1'b0;
                exp_d = 7'd1;
            end
        end else if (state_q == ST_IDLE) begin
            exp_d = 7'd0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q <= 7'd0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign seq_err = err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign TXD     = txd_q;
    assign TXK     = txk_q;
    assign CRC_OUT = crc_q;
    assign SEQ_ERR = seq_err;

endmodule
